lap_recorder: RTL

//  Lap/split memory downstream of the stopwatch counter, upstream of the 7-seg driver.

---
 rtl/lap_recorder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lap_recorder.sv
// Lap/split memory between the stopwatch counter and the seven-segment driver.
// Captures live time on lap_pulse and replays stored laps oldest-first on view_pulse.
module lap_recorder #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lap_pulse,
  input  logic             view_pulse,
  input  logic             clear_pulse,
  input  logic [3:0]       cur_d0,
  input  logic [5:0]       cur_d12,
  input  logic [3:0]       cur_d3,
  output logic [3:0]       out_d0,
  output logic [5:0]       out_d12,
  output logic [3:0]       out_d3,
  output logic             view_mode,
  output logic [IDX_W-1:0] view_idx,
  output logic [IDX_W:0]   lap_count,
  output logic             full,
  output logic             overflow
);

  // Handshake: all three pulse inputs are single-cycle strobes with no back-pressure;
  // each is acted on in the cycle it is high, with clear_pulse masking lap/view.

  typedef enum logic {LIVE = 1'b0, RECALL = 1'b1} state_t;

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W:0]   count_n;
  logic             ovf_n;
  logic             wr_en;
  logic [13:0]      mem [DEPTH];
  logic [13:0]      cur_word;
  logic [13:0]      rd_word;

  assign cur_word  = {cur_d3, cur_d12, cur_d0};
  assign rd_word   = mem[view_idx];
  assign full      = (lap_count == DEPTH_CNT);
  assign view_mode = (state == RECALL);

  always_comb begin
    state_n = state;
    idx_n   = view_idx;
    count_n = lap_count;
    ovf_n   = overflow;
    wr_en   = 1'b0;
    if (clear_pulse) begin
      state_n = LIVE;
      idx_n   = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end else begin
      if (lap_pulse) begin
        if (lap_count < DEPTH_CNT) begin
          wr_en   = 1'b1;
          count_n = lap_count + CNT_ONE;
        end else begin
          ovf_n = 1'b1;
        end
      end
      // View decisions use the pre-capture lap_count, so a same-cycle lap cannot extend recall.
      if (view_pulse) begin
        case (state)
          LIVE: begin
            if (lap_count != '0) begin
              state_n = RECALL;
              idx_n   = '0;
            end
          end
          RECALL: begin
            if ({1'b0, view_idx} < (lap_count - CNT_ONE)) begin
              idx_n = view_idx + IDX_ONE;
            end else begin
              state_n = LIVE;
              idx_n   = '0;
            end
          end
          default: begin
            state_n = LIVE;
            idx_n   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LIVE;
      view_idx  <= '0;
      lap_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      view_idx  <= idx_n;
      lap_count <= count_n;
      overflow  <= ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[lap_count[IDX_W-1:0]] <= cur_word;
    end
  end

  // Display mux uses the registered state/index, giving a uniform one-cycle latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_d0  <= '0;
      out_d12 <= '0;
      out_d3  <= '0;
    end else if (state == RECALL) begin
      {out_d3, out_d12, out_d0} <= rd_word;
    end else begin
      {out_d3, out_d12, out_d0} <= cur_word;
    end
  end

endmodule
